// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store engine with req/gnt/rvalid data-memory handshake.
module load_store_unit (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  input  logic        mem_write_i,
  input  logic [2:0]  width_src_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        misaligned_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3;
  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  ws_q, ws_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ld_q, ld_d;
  logic [3:0]  be_q, be_d;
  logic        is_byte, is_half, mis, accept;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ext;
  always_comb begin
    is_byte = width_src_i[1:0] == 2'b01;
    is_half = width_src_i[1:0] == 2'b10;
    mis     = is_half ? addr_i[0] : is_byte ? 1'b0 : |addr_i[1:0];
    accept  = state_q == IDLE && valid_i && !mis;
    lb      = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    lh      = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    ext     = ws_q[1:0] == 2'b01 ? {{24{~ws_q[2] & lb[7]}}, lb} :
              ws_q[1:0] == 2'b10 ? {{16{~ws_q[2] & lh[15]}}, lh} : mem_rdata_i;
    state_d = state_q == IDLE ? (accept ? REQ : IDLE) :
              state_q == REQ  ? (mem_gnt_i ? (we_q ? RESP : WAIT) : REQ) :
              state_q == WAIT ? (mem_rvalid_i ? RESP : WAIT) : IDLE;
    we_d    = accept ? mem_write_i : we_q;
    ws_d    = accept ? width_src_i : ws_q;
    addr_d  = accept ? addr_i : addr_q;
    be_d    = !accept ? be_q : is_byte ? 4'b0001 << addr_i[1:0] :
              is_half ? 4'b0011 << addr_i[1:0] : 4'b1111;
    wdata_d = !accept ? wdata_q : is_byte ? {4{store_data_i[7:0]}} :
              is_half ? {2{store_data_i[15:0]}} : store_data_i;
    ld_d    = state_q == WAIT && mem_rvalid_i ? ext : ld_q;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      ws_q    <= 3'b0;
      addr_q  <= 32'b0;
      be_q    <= 4'b0;
      wdata_q <= 32'b0;
      ld_q    <= 32'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      ws_q    <= ws_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      ld_q    <= ld_d;
    end
  end
  assign stall_o      = accept || state_q == REQ || state_q == WAIT;
  assign misaligned_o = state_q == IDLE && valid_i && mis;
  assign load_valid_o = state_q == RESP && !we_q;
  assign load_data_o  = ld_q;
  assign mem_req_o    = state_q == REQ;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = {addr_q[31:2], 2'b00};
  assign mem_be_o     = be_q;
  assign mem_wdata_o  = wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: vector table, handshake corner cases and randomized model check.
module tb_load_store_unit;
  logic        clk_i = 0, reset_i = 1, valid_i = 0, mem_write_i = 0;
  logic [2:0]  width_src_i = 0;
  logic [31:0] addr_i = 0, store_data_i = 0, mem_rdata_i = 0;
  logic        mem_gnt_i = 0, mem_rvalid_i = 0;
  logic        stall_o, load_valid_o, misaligned_o, mem_req_o, mem_we_o;
  logic [31:0] load_data_o, mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  int n_cmp = 0, n_fail = 0;
  logic [31:0] last_ld = 0;

  load_store_unit dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .mem_write_i(mem_write_i),
    .width_src_i(width_src_i), .addr_i(addr_i), .store_data_i(store_data_i),
    .stall_o(stall_o), .load_data_o(load_data_o), .load_valid_o(load_valid_o),
    .misaligned_o(misaligned_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [2:0]  ws;
    logic [31:0] addr, sd, rdata;
    logic [3:0]  be;
    logic [31:0] wdata, ld;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int sz(input logic [2:0] ws);
    return ws[1:0] == 2'b01 ? 1 : ws[1:0] == 2'b10 ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] ws, input logic [31:0] a);
    int s = sz(ws);
    return s == 4 ? 4'hF : 4'(((1 << s) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] ws, input logic [31:0] sd);
    int s = sz(ws);
    return s == 1 ? sd[7:0] * 32'h01010101 : s == 2 ? sd[15:0] * 32'h00010001 : sd;
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] ws, input logic [31:0] a, input logic [31:0] rd);
    int s = sz(ws);
    int sh;
    logic [31:0] mask, v;
    if (s == 4) return rd;
    sh = s == 1 ? int'(a % 4) * 8 : ((a % 4) >= 2 ? 16 : 0);
    mask = s == 1 ? 32'hFF : 32'hFFFF;
    v = (rd >> sh) & mask;
    if (!ws[2] && v[8 * s - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic bit m_mis(input logic [2:0] ws, input logic [31:0] a);
    return (a % sz(ws)) != 0;
  endfunction

  // Holds valid_i like a stalled pipeline until stall_o drops, then releases it.
  task automatic run_op(input logic we, input logic [2:0] ws, input logic [31:0] a, sd, rdw,
                        input int gd, rdly, output int stalls, lvs, lv_at,
                        output logic [31:0] ld, ad_s, wd_s, output logic [3:0] be_s,
                        output logic we_s, stable, done);
    int reqs, gc;
    bit rv_sent;
    @(negedge clk_i);
    valid_i = 1; mem_write_i = we; width_src_i = ws; addr_i = a; store_data_i = sd;
    stalls = 0; lvs = 0; lv_at = -1; reqs = 0; gc = -1; rv_sent = 0;
    stable = 1; done = 0; ld = 0; ad_s = 0; wd_s = 0; be_s = 0; we_s = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = $urandom;
      if (load_valid_o) begin lvs++; lv_at = cyc; end
      if (mem_req_o) begin
        if (reqs == 0) begin
          ad_s = mem_addr_o; wd_s = mem_wdata_o; be_s = mem_be_o; we_s = mem_we_o;
        end else if (ad_s !== mem_addr_o || wd_s !== mem_wdata_o || be_s !== mem_be_o || we_s !== mem_we_o)
          stable = 0;
        reqs++;
        if (reqs == gd + 1) begin mem_gnt_i = 1; gc = cyc; end
      end
      if (!we && gc >= 0 && !rv_sent && cyc == gc + 1 + rdly) begin
        mem_rvalid_i = 1; mem_rdata_i = rdw; rv_sent = 1;
      end
      if (stall_o) stalls++;
      else if (cyc > 0) begin done = 1; ld = load_data_o; end
      @(negedge clk_i);
    end
    valid_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
    #1;
    if (load_valid_o) lvs++;
  endtask

  task automatic check_op(input string nm, input logic we, input logic [2:0] ws,
                          input logic [31:0] a, sd, rdw, input int gd, rdly,
                          input logic [3:0] ebe, input logic [31:0] ewd, eld);
    int stalls, lvs, lv_at;
    logic [31:0] ld, ad_s, wd_s;
    logic [3:0] be_s;
    logic we_s, stable, done;
    run_op(we, ws, a, sd, rdw, gd, rdly, stalls, lvs, lv_at, ld, ad_s, wd_s, be_s, we_s, stable, done);
    chk({nm, " done"}, 32'(done), 1);
    chk({nm, " be"}, 32'(be_s), 32'(ebe));
    chk({nm, " addr"}, ad_s, a & ~32'h3);
    chk({nm, " we"}, 32'(we_s), 32'(we));
    chk({nm, " stable"}, 32'(stable), 1);
    chk({nm, " stalls"}, stalls, we ? 2 + gd : 3 + gd + rdly);
    chk({nm, " lv_cnt"}, lvs, we ? 0 : 1);
    if (we) chk({nm, " wdata"}, wd_s, ewd);
    else begin
      chk({nm, " lv_at"}, lv_at, 3 + gd + rdly);
      last_ld = eld;
    end
    chk({nm, " ld"}, ld, last_ld);
  endtask

  task automatic check_mis(input string nm, input logic we, input logic [2:0] ws, input logic [31:0] a);
    @(negedge clk_i);
    valid_i = 1; mem_write_i = we; width_src_i = ws; addr_i = a;
    #1;
    chk({nm, " mis"}, 32'(misaligned_o), 1);
    chk({nm, " stall"}, 32'(stall_o), 0);
    @(negedge clk_i);
    #1;
    chk({nm, " req"}, 32'(mem_req_o), 0);
    chk({nm, " stall2"}, 32'(stall_o), 0);
    valid_i = 0;
  endtask

  vec_t vt[14];
  logic lvseen;

  initial begin
    vt[0]  = '{0, 3'b000, 32'h100, 0, 32'hDEADBEEF, 4'b1111, 0, 32'hDEADBEEF};
    vt[1]  = '{0, 3'b001, 32'h103, 0, 32'h80FF7F01, 4'b1000, 0, 32'hFFFFFF80};
    vt[2]  = '{0, 3'b101, 32'h103, 0, 32'h80FF7F01, 4'b1000, 0, 32'h00000080};
    vt[3]  = '{0, 3'b010, 32'h102, 0, 32'h80FF7F01, 4'b1100, 0, 32'hFFFF80FF};
    vt[4]  = '{0, 3'b110, 32'h100, 0, 32'h80FF7F01, 4'b0011, 0, 32'h00007F01};
    vt[5]  = '{0, 3'b001, 32'h101, 0, 32'h80FF7F01, 4'b0010, 0, 32'h0000007F};
    vt[6]  = '{0, 3'b001, 32'h102, 0, 32'h80FF7F01, 4'b0100, 0, 32'hFFFFFFFF};
    vt[7]  = '{1, 3'b001, 32'h101, 32'h12345678, 0, 4'b0010, 32'h78787878, 0};
    vt[8]  = '{1, 3'b010, 32'h102, 32'h12345678, 0, 4'b1100, 32'h56785678, 0};
    vt[9]  = '{1, 3'b000, 32'h100, 32'h12345678, 0, 4'b1111, 32'h12345678, 0};
    vt[10] = '{0, 3'b011, 32'h104, 0, 32'hCAFEF00D, 4'b1111, 0, 32'hCAFEF00D};
    vt[11] = '{0, 3'b100, 32'h108, 0, 32'h8000ABCD, 4'b1111, 0, 32'h8000ABCD};
    vt[12] = '{1, 3'b111, 32'h10C, 32'hA5A5C3C3, 0, 4'b1111, 32'hA5A5C3C3, 0};
    vt[13] = '{1, 3'b101, 32'h103, 32'h000000E7, 0, 4'b1000, 32'hE7E7E7E7, 0};

    #3;
    chk("rst req", 32'(mem_req_o), 0);
    chk("rst we", 32'(mem_we_o), 0);
    chk("rst be", 32'(mem_be_o), 0);
    chk("rst addr", mem_addr_o, 0);
    chk("rst wdata", mem_wdata_o, 0);
    chk("rst ld", load_data_o, 0);
    chk("rst lv", 32'(load_valid_o), 0);
    chk("rst stall", 32'(stall_o), 0);
    chk("rst mis", 32'(misaligned_o), 0);
    @(negedge clk_i);
    reset_i = 0;

    for (int i = 0; i < 14; i++)
      check_op($sformatf("vec%0d", i), vt[i].we, vt[i].ws, vt[i].addr, vt[i].sd, vt[i].rdata,
               0, 0, vt[i].be, vt[i].wdata, vt[i].ld);

    check_mis("mis_half", 0, 3'b010, 32'h101);
    check_mis("mis_word", 1, 3'b000, 32'h102);

    check_op("gnt4_st", 1, 3'b010, 32'h202, 32'h0000BEEF, 0, 4, 0, 4'b1100, 32'hBEEFBEEF, 0);
    check_op("gnt4_ld", 0, 3'b001, 32'h201, 0, 32'h11228833, 4, 2, 4'b0010, 0, 32'hFFFFFF88);

    // Abort a load in WAIT with reset; a late rvalid must not produce a result.
    @(negedge clk_i);
    valid_i = 1; mem_write_i = 0; width_src_i = 3'b000; addr_i = 32'h300;
    @(negedge clk_i);
    #1;
    chk("rstw req", 32'(mem_req_o), 1);
    mem_gnt_i = 1;
    @(negedge clk_i);
    mem_gnt_i = 0;
    #1;
    chk("rstw stall_wait", 32'(stall_o), 1);
    reset_i = 1; valid_i = 0;
    #1;
    chk("rstw req0", 32'(mem_req_o), 0);
    chk("rstw stall0", 32'(stall_o), 0);
    chk("rstw ld0", load_data_o, 0);
    last_ld = 0;
    @(negedge clk_i);
    reset_i = 0;
    lvseen = 0;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid_i = 1; mem_rdata_i = 32'h55AA55AA;
      @(negedge clk_i);
      #1;
      lvseen = lvseen | load_valid_o | mem_req_o;
    end
    mem_rvalid_i = 0;
    chk("rstw no_resp", 32'(lvseen), 0);
    chk("rstw ld_hold", load_data_o, 0);

    for (int i = 0; i < 40; i++) begin
      logic we;
      logic [2:0] ws;
      logic [31:0] a, sd, rd;
      we = 1'($urandom % 2);
      ws = 3'($urandom % 8);
      a = 32'h400 + ($urandom % 64);
      sd = $urandom;
      rd = $urandom;
      if (m_mis(ws, a)) check_mis($sformatf("rnd%0d", i), we, ws, a);
      else check_op($sformatf("rnd%0d", i), we, ws, a, sd, rd, int'($urandom % 3), int'($urandom % 3),
                    m_be(ws, a), m_wd(ws, sd), m_ld(ws, a, rd));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
